pll_lock_seq: RTL

PLL reset/lock sequencer running on the PLL reference clock. Drives the PLL `rst` pin with a defined power-up pulse, waits for `locked` with a timeout and bounded retries, and requires lock to stay stable before releasing the downstream system reset. On loss of lock it re-runs the sequence and counts the event. It sits beside the clock-generation PLL and gates reset for all logic clocked by `outclk_0`.

---
 rtl/pll_lock_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer on the PLL reference clock.
// Pulses the PLL reset, waits for lock with a timeout and bounded retries,
// requires lock to hold stable before releasing the downstream reset, and
// re-runs the sequence (counting the event) whenever lock drops in RUN.
module pll_lock_seq #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 50000,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned MAX_RETRIES      = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lost_lock,
  output logic [7:0] relock_count
);

  // The shared counter never holds more than the largest per-state limit minus one.
  localparam int unsigned CntMax12 = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES
                                                                       : LOCK_TIMEOUT;
  localparam int unsigned CntMax   = (CntMax12 > STABLE_CYCLES) ? CntMax12 : STABLE_CYCLES;
  localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned TriesW   = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CntW-1:0]   RstLast     = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [TriesW-1:0] TriesLast   = TriesW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TriesW-1:0] tries_q, tries_d;
  logic [7:0]        relock_d;
  logic              lost_d;
  logic              lock_meta_q;
  logic              lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s      <= lock_meta_q;
    end
  end

  // Next-state, counter, retry and lock-loss bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    tries_d  = tries_q;
    lost_d   = 1'b0;
    relock_d = relock_count;
    case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        // Lock arriving on the timeout cycle takes priority over the retry.
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d   = '0;
          state_d = StResetPll;
          if (MAX_RETRIES != 0) begin
            tries_d = tries_q + TriesW'(1);
            if (tries_q == TriesLast) begin
              state_d = StFail;
            end
          end
        end
      end
      StStable: begin
        // A lock glitch here restarts the pulse but is not a failed attempt.
        if (!lock_s) begin
          state_d = StResetPll;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          tries_d = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d  = StResetPll;
          cnt_d    = '0;
          lost_d   = 1'b1;
          relock_d = (relock_count != 8'hFF) ? relock_count + 8'd1 : relock_count;
        end
      end
      StFail: begin
        cnt_d = cnt_q;
        if (retry) begin
          state_d = StResetPll;
          cnt_d   = '0;
          tries_d = '0;
        end
      end
      default: begin
        state_d = StResetPll;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= StResetPll;
      cnt_q        <= '0;
      tries_q      <= '0;
      relock_count <= 8'd0;
      lost_lock    <= 1'b0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tries_q      <= tries_d;
      relock_count <= relock_d;
      lost_lock    <= lost_d;
      pll_rst      <= (state_d == StResetPll);
      sys_rst      <= (state_d != StRun);
      ready        <= (state_d == StRun);
      fail         <= (state_d == StFail);
    end
  end

endmodule
